serial_word_deserializer: RTL
=============================

// Module: serial_word_deserializer
// PURPOSE
//   Receive end of the serial link driven by our shift-register transmitters. Serial bits arrive
//   MSB-first (left-shift sender) or LSB-first (right-shift sender), with a bit strobe and a
//   start-of-frame marker. The block reassembles WIDTH-bit words and presents each one on a
//   parallel valid/ready port. Sticky flags report overflow and framing errors.
// PARAMETERS
//   WIDTH   4   word length in bits; legal range 2..32
// PORTS
//   clk      in   1      single clock; all logic on posedge
//   rst_n    in   1      reset, synchronous, active-low
//   sin_i    in   1      serial data bit
//   sval_i   in   1      sin_i valid this cycle
//   sof_i    in   1      first bit of a frame; only meaningful when sval_i=1
//   dir_i    in   1      0 = MSB-first, 1 = LSB-first; sampled on the SOF bit only
//   clr_i    in   1      clears ovf_o and ferr_o
//   prdy_i   in   1      downstream ready
//   pout_o   out  WIDTH  assembled word
//   pval_o   out  1      pout_o valid
//   busy_o   out  1      frame in progress (state == RECV)
//   ovf_o    out  1      sticky: completed word dropped because output buffer was full
//   ferr_o   out  1      sticky: SOF arrived mid-frame
// BEHAVIOUR
//   Reset (rst_n=0 at posedge), regardless of other inputs:
//     pout_o=0, pval_o=0, busy_o=0, ovf_o=0, ferr_o=0, state=IDLE, bit count=0,
//     partial word discarded.
//   All outputs are registered.
//   FSM IDLE:
//     sval_i&sof_i -> capture bit, latch dir_q<=dir_i, cnt<=1, go RECV.
//     sval_i without sof_i -> bit ignored, no flag.
//   FSM RECV:
//     sval_i&!sof_i -> shift bit in, cnt++.
//     Cycles with sval_i=0 are gaps: no change to shift reg or cnt.
//     sval_i&sof_i -> ferr_o<=1, partial word discarded, new frame starts with this bit
//     (cnt<=1, dir_q re-latched).
//     Bit accepted at cnt==WIDTH-1 -> word complete, go IDLE, cnt<=0.
//   Shift rules:
//     MSB-first: sh <= {sh[WIDTH-2:0], sin_i}
//     LSB-first: sh <= {sin_i, sh[WIDTH-1:1]}
//     Completed word = shift result including the final bit.
//   Output buffer (one entry):
//     Transfer occurs when pval_o&prdy_i.
//     Word completes in cycle N and buffer is empty or draining in cycle N -> pout_o=word and
//     pval_o=1 from cycle N+1. Latency is 1 cycle from the final bit.
//     Buffer full and not draining -> new word dropped, ovf_o<=1, pout_o/pval_o unchanged.
//     pout_o is stable while pval_o&!prdy_i.
//     pval_o drops after the transfer unless a new word loads in the same cycle, so
//     back-to-back frames give continuous pval_o.
//   Flags: clr_i clears ovf_o/ferr_o. Set and clear in the same cycle -> set wins.
//   Throughput: one bit per cycle. A new SOF is accepted in the cycle after completion.
// STRUCTURE
//   Package serdes_pkg:
//     typedef enum logic {IDLE, RECV} deser_state_t
//     localparams DIR_MSB_FIRST=1'b0, DIR_LSB_FIRST=1'b1
//     Shared with the transmitter side.
//   Sub-module word_hold_buf:
//     one-entry valid/ready holding register (load, full, drain) -> pout_o/pval_o.
//   Top level holds the FSM, shift register, $clog2(WIDTH) counter and sticky flags.
// TESTING (WIDTH=4)
//   1. MSB-first bits 1,0,1,1 (sof on first), prdy_i=1
//      -> pout_o=4'b1011, pval_o high exactly 1 cycle, one cycle after the 4th bit.
//   2. LSB-first bits 1,0,1,1 -> pout_o=4'b1101. Frames back-to-back with no gap
//      -> pval_o continuous.
//   3. MSB-first 1,0,1,1 with 2 idle cycles between bits
//      -> pout_o=4'hB, busy_o high from the first bit through the last.
//   4. prdy_i=0; frames 4'hA then 4'h5 -> pout_o stays 4'hA, ovf_o=1. Then prdy_i=1 for one
//      cycle -> pval_o=0 (4'h5 was lost). Pulse clr_i -> ovf_o=0.
//   5. MSB-first 1,1, then sof with bits 0,1,1,0 -> ferr_o=1, pout_o=4'h6, no word from the
//      partial frame.
//   6. rst_n=0 after 2 bits of a frame -> next edge all outputs 0, busy_o=0. Full frame 4'h9
//      afterwards -> pout_o=4'h9.

Source files
------------

// File: rtl/serdes_pkg.sv
// Shared definitions for the serial link: receiver FSM states and bit-order encodings.
// The transmitter side imports the same package so both ends agree on the dir encoding.
package serdes_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } deser_state_t;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/word_hold_buf.sv
// One-entry valid/ready holding register for assembled words.
// It accepts a load when empty or draining; otherwise the caller must treat the word as dropped.
module word_hold_buf #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             prdy_i,
    output logic             accept_o,
    output logic [WIDTH-1:0] pout_o,
    output logic             pval_o
);

    logic [WIDTH-1:0] pout_q, pout_d;
    logic             pval_q, pval_d;

    assign accept_o = !pval_q || prdy_i;

    always_comb begin
        pout_d = pout_q;
        pval_d = pval_q;
        if (load_i && accept_o) begin
            pout_d = data_i;
            pval_d = 1'b1;
        end else if (pval_q && prdy_i) begin
            pval_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pout_q <= '0;
            pval_q <= 1'b0;
        end else begin
            pout_q <= pout_d;
            pval_q <= pval_d;
        end
    end

    assign pout_o = pout_q;
    assign pval_o = pval_q;

endmodule

// File: rtl/serial_word_deserializer.sv
// Serial-to-parallel receiver: reassembles WIDTH-bit words from an MSB- or LSB-first bit stream
// framed by a start-of-frame marker, with sticky overflow and framing-error flags.
module serial_word_deserializer
    import serdes_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin_i,
    input  logic             sval_i,
    input  logic             sof_i,
    input  logic             dir_i,
    input  logic             clr_i,
    input  logic             prdy_i,
    output logic [WIDTH-1:0] pout_o,
    output logic             pval_o,
    output logic             busy_o,
    output logic             ovf_o,
    output logic             ferr_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    deser_state_t     state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             dir_q, dir_d;
    logic             ovf_q, ovf_d;
    logic             ferr_q, ferr_d;
    logic             word_done;
    logic             ferr_set;
    logic             buf_accept;

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sh,
                                                  input logic bit_in,
                                                  input logic dir);
        if (dir == DIR_MSB_FIRST)
            return {sh[WIDTH-2:0], bit_in};
        else
            return {bit_in, sh[WIDTH-1:1]};
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        dir_d     = dir_q;
        word_done = 1'b0;
        ferr_set  = 1'b0;
        case (state_q)
            IDLE: begin
                if (sval_i && sof_i) begin
                    sh_d    = shift_in(sh_q, sin_i, dir_i);
                    dir_d   = dir_i;
                    cnt_d   = CW'(1);
                    state_d = RECV;
                end
            end
            RECV: begin
                if (sval_i && sof_i) begin
                    // Restart on the new SOF bit; the partial word is simply overwritten.
                    ferr_set = 1'b1;
                    sh_d     = shift_in(sh_q, sin_i, dir_i);
                    dir_d    = dir_i;
                    cnt_d    = CW'(1);
                end else if (sval_i) begin
                    sh_d = shift_in(sh_q, sin_i, dir_q);
                    if (cnt_q == CNT_LAST) begin
                        word_done = 1'b1;
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Set has priority over clear on both sticky flags.
        ovf_d  = (word_done && !buf_accept) ? 1'b1 : (clr_i ? 1'b0 : ovf_q);
        ferr_d = ferr_set ? 1'b1 : (clr_i ? 1'b0 : ferr_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= DIR_MSB_FIRST;
            ovf_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            ovf_q   <= ovf_d;
            ferr_q  <= ferr_d;
        end
    end

    // Shift data needs no reset: the bit counter restarts every frame.
    always_ff @(posedge clk) begin
        sh_q <= sh_d;
    end

    word_hold_buf #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (word_done),
        .data_i  (sh_d),
        .prdy_i  (prdy_i),
        .accept_o(buf_accept),
        .pout_o  (pout_o),
        .pval_o  (pval_o)
    );

    assign busy_o = (state_q == RECV);
    assign ovf_o  = ovf_q;
    assign ferr_o = ferr_q;

endmodule
